// File: rtl/cnt_check.sv
// Sequence checker for a free-running up-counter: acquires, locks after LOCK_LEN
// consecutive +1 samples, then reports sequence errors and counts wrap-arounds.
module cnt_check #(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [7:0]       wrap_cnt,
    output logic [WIDTH-1:0] last
);

    typedef enum logic [1:0] {
        ACQ,
        SYNC,
        LOCK
    } state_t;

    localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);

    state_t           state, state_n;
    logic [3:0]       match_len, match_len_n;
    logic [WIDTH-1:0] last_n;
    logic [7:0]       wrap_cnt_n;
    logic [7:0]       err_cnt_n;
    logic [7:0]       err_base;
    logic             seq_err;
    logic             match;
    logic             wrap_seen;

    assign match     = (cnt == last + WIDTH'(1));
    assign wrap_seen = (&last) && (cnt == '0);

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        match_len_n = match_len;
        last_n      = last;
        wrap_cnt_n  = wrap_cnt;
        seq_err     = 1'b0;

        if (en) begin
            last_n = cnt;
            unique case (state)
                ACQ: begin
                    match_len_n = '0;
                    state_n     = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        match_len_n = match_len + 4'd1;
                        if (match_len + 4'd1 == LOCK_LEN_C) begin
                            state_n = LOCK;
                        end
                    end else begin
                        match_len_n = '0;
                    end
                end
                LOCK: begin
                    if (match) begin
                        if (wrap_seen) begin
                            wrap_cnt_n = wrap_cnt + 8'd1;
                        end
                    end else begin
                        seq_err     = 1'b1;
                        match_len_n = '0;
                        state_n     = SYNC;
                    end
                end
                default: begin
                    match_len_n = '0;
                    state_n     = ACQ;
                end
            endcase
        end
    end

    // Clear applies first, so a coincident error leaves the count at one.
    always_comb begin
        err_base  = clr_err ? 8'd0 : err_cnt;
        err_cnt_n = err_base;
        if (seq_err && (err_base != 8'hFF)) begin
            err_cnt_n = err_base + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACQ;
            match_len <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
            last      <= '0;
        end else begin
            state     <= state_n;
            match_len <= match_len_n;
            locked    <= (state_n == LOCK);
            err       <= seq_err;
            err_cnt   <= err_cnt_n;
            wrap_cnt  <= wrap_cnt_n;
            last      <= last_n;
        end
    end

endmodule
